// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - instruction decode stage with output register, HLT drain FSM, optional perf counter (CTRL_DECODE_PERF_CNT_EN)
module ctrl_decode_pipe #(
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [2:0]        alu_op,
    output logic              reg_dst,
    output logic              branch,
    output logic              branch_reg,
    output logic              mem_read,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              mem_write,
    output logic              reg_write,
    output logic              llb,
    output logic              lhb,
    output logic              pcs,
    output logic              halt,
    output logic [2:0]        cond,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [2:0] cond;
        logic       reg_dst;
        logic       branch;
        logic       branch_reg;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_src;
        logic       mem_write;
        logic       reg_write;
        logic       llb;
        logic       lhb;
        logic       pcs;
        logic       halt;
    } bundle_t;

    state_t     state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic       out_valid_q, out_valid_d;
    bundle_t    bundle_q, bundle_d;
    bundle_t    dec;
    logic [3:0] opcode;
    logic       accept;
    logic       unused_instr_bits;

    assign opcode            = instr[DATA_W-1 -: 4];
    assign unused_instr_bits = ^instr[DATA_W-8:0];
    assign in_ready          = (state_q == RUN) && (!out_valid_q || out_ready);
    // A flushed offer is treated as never accepted: no bundle, no HLT, no count.
    assign accept            = in_valid && in_ready && !flush;

    always_comb begin
        dec = '0;
        if (!opcode[3]) begin
            dec.alu_op    = opcode[2:0];
            dec.reg_dst   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = (opcode[2:0] == 3'd4) || (opcode[2:0] == 3'd5) || (opcode[2:0] == 3'd6);
        end else begin
            case (opcode[2:0])
                3'b000: begin
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.alu_src    = 1'b1;
                end
                3'b001: begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                end
                3'b010: begin
                    dec.llb       = 1'b1;
                    dec.reg_write = 1'b1;
                end
                3'b011: begin
                    dec.lhb       = 1'b1;
                    dec.reg_write = 1'b1;
                end
                3'b100: begin
                    dec.branch = 1'b1;
                    dec.cond   = instr[DATA_W-5 -: 3];
                end
                3'b101: begin
                    dec.branch     = 1'b1;
                    dec.branch_reg = 1'b1;
                    dec.cond       = instr[DATA_W-5 -: 3];
                end
                3'b110: begin
                    dec.pcs       = 1'b1;
                    dec.reg_write = 1'b1;
                end
                default: dec.halt = 1'b1;
            endcase
        end
    end

    // Bundle is zeroed whenever it is not valid so idle outputs read as 0.
    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            RUN: begin
                if (accept && (opcode == 4'hF)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 4'd0;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d     = RUN;
                    drain_cnt_d = 4'd0;
                end else if (drain_cnt_q == 4'(DRAIN_CYCLES - 1)) begin
                    state_d     = HALTED;
                    drain_cnt_d = 4'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

`ifdef CTRL_DECODE_PERF_CNT_EN
    logic [15:0] instr_count_q, instr_count_d;

    always_comb begin
        instr_count_d = instr_count_q;
        if (accept && (instr_count_q != 16'hFFFF)) begin
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_count_q <= 16'h0000;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
`else
    assign instr_count = 16'h0000;
`endif

    assign out_valid = out_valid_q;
    assign halted    = (state_q == HALTED);
    assign {alu_op, cond, reg_dst, branch, branch_reg, mem_read, mem_to_reg, alu_src,
            mem_write, reg_write, llb, lhb, pcs, halt} = bundle_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - directed self-checking bench for ctrl_decode_pipe
module tb_ctrl_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] instr;
    logic [2:0]  alu_op, cond;
    logic        reg_dst, branch, branch_reg, mem_read, mem_to_reg, alu_src;
    logic        mem_write, reg_write, llb, lhb, pcs, halt, halted;
    logic [15:0] instr_count;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

`ifdef CTRL_DECODE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // alu_op cond | reg_dst branch branch_reg mem_read mem_to_reg alu_src mem_write reg_write llb lhb pcs halt
    localparam logic [17:0] B_LW  = 18'b000_000_0_0_0_1_1_1_0_1_0_0_0_0;
    localparam logic [17:0] B_HLT = 18'b000_000_0_0_0_0_0_0_0_0_0_0_0_1;

    always #5 clk = ~clk;

    assign obs = {alu_op, cond, reg_dst, branch, branch_reg, mem_read, mem_to_reg, alu_src,
                  mem_write, reg_write, llb, lhb, pcs, halt};

    ctrl_decode_pipe #(.DATA_W(16), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .alu_op(alu_op),
        .reg_dst(reg_dst), .branch(branch), .branch_reg(branch_reg), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .mem_write(mem_write),
        .reg_write(reg_write), .llb(llb), .lhb(lhb), .pcs(pcs), .halt(halt), .cond(cond),
        .halted(halted), .instr_count(instr_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = 16'h0;
        step(); step();
        rst_n = 1'b1;
        exp_cnt = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (obs !== 18'h0) begin errors++; $display("FAIL reset_bundle got %h want 0", obs); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
        checks++; if (instr_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0", instr_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_decode();
        logic [15:0] vi [11];
        logic [17:0] ve [11];
        vi = '{16'h0123, 16'h4ABC, 16'h5000, 16'h7FFF, 16'h8123, 16'h9000,
               16'hA000, 16'hB000, 16'hC400, 16'hD5A0, 16'hE000};
        ve = '{18'b000_000_1_0_0_0_0_0_0_1_0_0_0_0,
               18'b100_000_1_0_0_0_0_1_0_1_0_0_0_0,
               18'b101_000_1_0_0_0_0_1_0_1_0_0_0_0,
               18'b111_000_1_0_0_0_0_0_0_1_0_0_0_0,
               B_LW,
               18'b000_000_0_0_0_0_0_1_1_0_0_0_0_0,
               18'b000_000_0_0_0_0_0_0_0_1_1_0_0_0,
               18'b000_000_0_0_0_0_0_0_0_1_0_1_0_0,
               18'b000_010_0_1_0_0_0_0_0_0_0_0_0_0,
               18'b000_010_0_1_1_0_0_0_0_0_0_0_0_0,
               18'b000_000_0_0_0_0_0_0_0_1_0_0_1_0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; instr = vi[i];
            step();
            exp_cnt++;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid[%0d] got %0b want 1", i, out_valid); end
            checks++; if (obs !== ve[i]) begin errors++; $display("FAIL decode_bundle[%0d] instr %h got %b want %b", i, vi[i], obs, ve[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || obs !== 18'h0) begin errors++; $display("FAIL decode_drop got v=%0b b=%h want v=0 b=0", out_valid, obs); end
        checks++; if (instr_count !== (PERF ? 16'(exp_cnt) : 16'h0)) begin errors++; $display("FAIL decode_count got %0d want %0d", instr_count, PERF ? exp_cnt : 0); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; instr = 16'h8123; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || obs !== B_LW) begin errors++; $display("FAIL bp_hold[%0d] got v=%0b b=%b want v=1 b=%b", i, out_valid, obs, B_LW); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_flush_accept();
        in_valid = 1'b1; instr = 16'hD5A0; flush = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || obs !== 18'h0) begin errors++; $display("FAIL flush_acc got v=%0b b=%h want v=0 b=0", out_valid, obs); end
        checks++; if (instr_count !== (PERF ? 16'(exp_cnt) : 16'h0)) begin errors++; $display("FAIL flush_acc_count got %0d want %0d", instr_count, PERF ? exp_cnt : 0); end
    endtask

    task automatic test_flush_drain();
        in_valid = 1'b1; instr = 16'hF000; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        exp_cnt++;
        checks++; if (out_valid !== 1'b1 || obs !== B_HLT) begin errors++; $display("FAIL fd_hlt_bundle got v=%0b b=%b want v=1 b=%b", out_valid, obs, B_HLT); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fd_drain_ready got %0b want 0", in_ready); end
        flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fd_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fd_in_ready got %0b want 1", in_ready); end
        step(); step(); step(); step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fd_halted got %0b want 0", halted); end
    endtask

    task automatic test_halt();
        in_valid = 1'b1; instr = 16'hF000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        exp_cnt++;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early[cycle %0d] got %0b want 0", c, halted); end
            step();
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_cycle4 got %0b want 1", halted); end
        in_valid = 1'b1; instr = 16'h0123;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got %0b want 0", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_ignore got %0b want 0", out_valid); end
        checks++; if (instr_count !== (PERF ? 16'(exp_cnt) : 16'h0)) begin errors++; $display("FAIL halt_count got %0d want %0d", instr_count, PERF ? exp_cnt : 0); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flush_ignored got %0b want 1", halted); end
    endtask

    task automatic test_reset_drain();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; exp_cnt = 0;
        in_valid = 1'b1; instr = 16'hF000; out_ready = 1'b0;
        step();
        instr = 16'h0123;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rd_setup got v=%0b r=%0b want v=1 r=0", out_valid, in_ready); end
        rst_n = 1'b0; flush = 1'b1;
        step();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || obs !== 18'h0) begin errors++; $display("FAIL rd_valid got v=%0b b=%h want v=0 b=0", out_valid, obs); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rd_halted got %0b want 0", halted); end
        checks++; if (instr_count !== 16'h0) begin errors++; $display("FAIL rd_count got %h want 0", instr_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rd_in_ready got %0b want 1", in_ready); end
        step(); step(); step(); step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rd_no_halt got %0b want 0", halted); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush_accept();
        test_flush_drain();
        test_halt();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction width (>=16); opcode = instr[DATA_W-1 -: 4].
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles from HLT issue to halted (1..15).
REQ-003 SHALL have ports, clock and reset first: clk input 1, rising-edge clock; rst_n input 1, reset synchronous, active-low.
REQ-004 in_valid input 1 instruction offered; in_ready output 1 block accepts; instr input DATA_W instruction word.
REQ-005 flush input 1 squash held/incoming instruction; out_ready input 1 consumer accepts.
REQ-006 out_valid output 1 control bundle valid; alu_op output 3; reg_dst, branch, branch_reg, mem_read, mem_to_reg, alu_src, mem_write, reg_write, llb, lhb, pcs, halt output 1 each.
REQ-007 cond output 3, branch condition; halted output 1, sticky halt status; instr_count output 16, accepted-instruction count.

Function
REQ-008 SHALL decode: 0xxx ALU: alu_op=opcode[2:0], reg_dst=1, reg_write=1, alu_src=1 only for 0100/0101/0110.
REQ-009 SHALL decode 1000 LW: mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, alu_op=000.
REQ-010 SHALL decode 1001 SW: mem_write=1, alu_src=1, alu_op=000.
REQ-011 SHALL decode 1010 LLB: llb=1, reg_write=1; 1011 LHB: lhb=1, reg_write=1.
REQ-012 SHALL decode 1100 B: branch=1; 1101 BR: branch=1, branch_reg=1; cond=instr[DATA_W-5 -: 3] for both, else 000.
REQ-013 SHALL decode 1110 PCS: pcs=1, reg_write=1; 1111 HLT: halt=1; every unlisted signal 0.
REQ-014 Output register single-entry; bundle SHALL appear on outputs 1 cycle after accept (in_valid && in_ready).
REQ-015 in_ready SHALL = (state==RUN) && (!out_valid || out_ready), combinational.
REQ-016 out_valid SHALL fall after out_ready with no new accept; bundle held stable while out_valid && !out_ready.
REQ-017 States RUN, DRAIN, HALTED; RUN->DRAIN on accepting HLT; DRAIN->HALTED after DRAIN_CYCLES cycles counted from cycle after HLT accept.
REQ-018 halted SHALL be 1 exactly in HALTED; HALTED exits only on reset.
REQ-019 flush SHALL clear out_valid next cycle, discard any same-cycle accept, and block instr_count increment for it.
REQ-020 flush in DRAIN SHALL return to RUN and clear drain counter (squashed HLT); flush in HALTED ignored.
REQ-021 When out_valid=0, all bundle outputs SHALL be 0.

Reset
REQ-022 rst_n=0 at clk edge SHALL set state RUN, out_valid 0, all bundle outputs 0, halted 0, drain counter 0, instr_count 0.
REQ-023 Reset mid-DRAIN or while holding an un-consumed bundle SHALL discard it; in_ready=1 first cycle after reset release.
REQ-024 Reset SHALL take priority over flush and accept.

Configuration
REQ-025 Macro CTRL_DECODE_PERF_CNT_EN defined: instr_count increments on each non-flushed accept, saturating at 16'hFFFF.
REQ-026 Macro undefined: instr_count port present, tied to 16'h0000, no counter flops.

Verification
REQ-027 ADD instr 16'h0123, out_ready=1 -> next cycle out_valid=1, alu_op=000, reg_dst=1, reg_write=1, alu_src=0.
REQ-028 LW 16'h8123 accepted, out_ready=0 for 3 cycles -> bundle (mem_read=1, mem_to_reg=1) stable 3 cycles, in_ready=0, then released.
REQ-029 HLT 16'hF000 accepted, DRAIN_CYCLES=3 -> halted=1 on 4th cycle after accept, in_ready=0 thereafter, new in_valid ignored.
REQ-030 HLT accepted then flush on next cycle -> state RUN, halted stays 0, in_ready=1 following cycle, out_valid=0.
REQ-031 BR 16'hD5A0 and flush same cycle -> out_valid stays 0; with macro, instr_count unchanged.
REQ-032 rst_n=0 during DRAIN with out_valid=1 -> next cycle out_valid=0, halted=0, instr_count=0, in_ready=1 after release.
